mm_adder_ctrl: RTL and testbench
================================

Name: mm_adder_ctrl

Overview:
- Tile sequencer for the mm_adder tile-accumulation datapath.
- On a start pulse it walks the output row-blocks. For each row-block it issues every A-tile read, then every B-tile read, to the tile buffer.
- It drives mm_adder's ptr_row, ptr_col and in_add_valid in alignment with the returning buffer data.
- It waits for a row-complete indication before advancing to the next row-block, and signals done after the last row-block.

Parameters:
M, 4, matrix rows
N, 4, matrix columns
M_TILE, 2, tile rows
N_TILE, 2, tile columns
DW_INT, 32, pointer width
ADDR_W, 8, tile-buffer address width

Ports:
clk  in  1  clock, all logic on the rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; accepted only in IDLE
abort  in  1  synchronous abort; next state is IDLE, no done pulse
hold  in  1  downstream stall; freezes issue
row_done  in  1  pulse from mm_adder (derived from out_flag): current row-block result is complete
rd_en  out  1  tile-buffer read strobe
rd_sel  out  1  0 = A buffer, 1 = B buffer
rd_addr  out  ADDR_W  tile index = pm*ITER_N + pn
ptr_row  out  DW_INT  to mm_adder ptr_row; aligned with in_add_valid
ptr_col  out  DW_INT  to mm_adder ptr_col; aligned with in_add_valid
in_add_valid  out  1  to mm_adder in_add_valid
busy  out  1  high in ISSUE_A, ISSUE_B, WAIT_ROW
done  out  1  one-cycle pulse at completion

Behaviour:
- Derived constants: ITER_M = (M+M_TILE-1)/M_TILE; ITER_N = (N+N_TILE-1)/N_TILE (ceiling division).
- Counters pm ∈ [0, ITER_M-1] and pn ∈ [0, ITER_N-1].
- Reset (async, reset_n=0): state=IDLE, pm=pn=0, row_done_seen=0. Every output is 0 while reset_n=0 and immediately after release.
- States: IDLE, ISSUE_A, ISSUE_B, WAIT_ROW, DONE. All outputs are registered.
- IDLE: start=1 → ISSUE_A with pm=pn=0.
- ISSUE_A and ISSUE_B:
  - Each cycle with hold=0: rd_en=1, rd_sel=(state==ISSUE_B), rd_addr=pm*ITER_N+pn; then pn increments.
  - When pn==ITER_N-1 the issue is made, pn wraps to 0, and the state moves ISSUE_A→ISSUE_B or ISSUE_B→WAIT_ROW.
  - hold=1: rd_en=0 and counters and state are frozen. hold is sampled in the same cycle the issue would occur.
- Read latency to data:
  - The tile buffer has a fixed 1-cycle read latency.
  - in_add_valid, ptr_row and ptr_col are rd_en, pm and pn delayed by exactly 1 cycle.
  - A read issued in the cycle before hold rises still produces its in_add_valid; it is never cancelled.
  - ptr_row and ptr_col hold their last values when in_add_valid=0.
- WAIT_ROW:
  - Advances when row_done=1 or row_done_seen=1, then clears row_done_seen.
  - If pm==ITER_M-1 → DONE. Otherwise pm++ and → ISSUE_A.
- row_done latch: a row_done pulse arriving outside WAIT_ROW sets row_done_seen, which is cleared on consumption or on abort. A second pulse before consumption has no additional effect.
- DONE: done=1 for this single cycle, then → IDLE. busy=0.
- start while not in IDLE is ignored.
- abort in any state:
  - Next state is IDLE; pm, pn and row_done_seen are cleared; rd_en=0 next cycle.
  - A read already issued still gives its in_add_valid one cycle later.
  - abort has priority over start and row_done in the same cycle.
- A row_done in WAIT_ROW coincident with hold is consumed normally, because hold only gates issue.
- Issue count per row-block is 2*ITER_N reads. Total reads are 2*ITER_M*ITER_N.

Test Plan:
- Nominal, defaults (ITER_M=ITER_N=2), start at cycle t:
  - rd_en at t+1..t+4 with (sel,addr) = (0,0),(0,1),(1,0),(1,1).
  - in_add_valid at t+2..t+5 with (ptr_row,ptr_col) = (0,0),(0,1),(0,0),(0,1).
  - row_done at t+7 → rd_en resumes at t+8 with (0,2),(0,3),(1,2),(1,3) and ptr_row=1.
  - row_done at t+14 → done=1 at t+15; busy low afterwards.
- hold: assert hold for 3 cycles starting at the second issue → rd_en low for those 3 cycles; the addr sequence is unchanged; in_add_valid shows a matching 3-cycle gap; total reads = 8.
- Early row_done: pulse row_done during ISSUE_B of row 0 → WAIT_ROW lasts 1 cycle, then row 1 issue begins. A second row_done in row 1 is still required before done.
- abort: assert abort during ISSUE_B of row 1 → next cycle state=IDLE, busy=0, done never pulses. A subsequent start restarts at addr 0 with pm=0.
- Async reset: drop reset_n mid-ISSUE_A → rd_en, in_add_valid, busy and done go 0 immediately. After release, start yields the nominal sequence.
- Non-divisible parameters: M=5, N=3, M_TILE=N_TILE=2 → ITER_M=3 and ITER_N=2, giving 12 reads with addr per row {0,1},{2,3},{4,5}; done follows the third row_done.

Source files
------------

// File: rtl/mm_adder_ctrl.sv
// Tile sequencer for the mm_adder tile-accumulation datapath.
// Walks output row-blocks, issues A then B tile reads per row-block, drives
// mm_adder's pointer/valid inputs one cycle behind each read, and waits for
// the row-complete indication before moving on.
module mm_adder_ctrl #(
  parameter int unsigned M      = 4,
  parameter int unsigned N      = 4,
  parameter int unsigned M_TILE = 2,
  parameter int unsigned N_TILE = 2,
  parameter int unsigned DW_INT = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  input  logic              row_done,
  output logic              rd_en,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DW_INT-1:0] ptr_row,
  output logic [DW_INT-1:0] ptr_col,
  output logic              in_add_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ITER_M = (M + M_TILE - 1) / M_TILE;
  localparam int unsigned ITER_N = (N + N_TILE - 1) / N_TILE;
  localparam int unsigned PM_W   = (ITER_M > 1) ? $clog2(ITER_M) : 1;
  localparam int unsigned PN_W   = (ITER_N > 1) ? $clog2(ITER_N) : 1;

  localparam logic [PM_W-1:0] PM_LAST = PM_W'(ITER_M - 1);
  localparam logic [PN_W-1:0] PN_LAST = PN_W'(ITER_N - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_A  = 3'd1,
    S_ISSUE_B  = 3'd2,
    S_WAIT_ROW = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [PM_W-1:0]   pm_q, pm_d;
  logic [PN_W-1:0]   pn_q, pn_d;
  logic              row_done_seen_q, row_done_seen_d;

  // Issue-side registers (tile-buffer request) and the tile coordinates of
  // the request, kept so the data-side pointers can follow one cycle later.
  logic              rd_en_q, rd_en_d;
  logic              rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [PM_W-1:0]   iss_pm_q, iss_pm_d;
  logic [PN_W-1:0]   iss_pn_q, iss_pn_d;

  // Data-side registers, aligned with the returning buffer data.
  logic              in_add_valid_q, in_add_valid_d;
  logic [DW_INT-1:0] ptr_row_q, ptr_row_d;
  logic [DW_INT-1:0] ptr_col_q, ptr_col_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] tile_addr_c;

  // Linear tile index of the current (pm, pn) position.
  assign tile_addr_c = ADDR_W'(32'(pm_q) * ITER_N + 32'(pn_q));

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      pm_q            <= '0;
      pn_q            <= '0;
      row_done_seen_q <= 1'b0;
      rd_en_q         <= 1'b0;
      rd_sel_q        <= 1'b0;
      rd_addr_q       <= '0;
      iss_pm_q        <= '0;
      iss_pn_q        <= '0;
      in_add_valid_q  <= 1'b0;
      ptr_row_q       <= '0;
      ptr_col_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      pm_q            <= pm_d;
      pn_q            <= pn_d;
      row_done_seen_q <= row_done_seen_d;
      rd_en_q         <= rd_en_d;
      rd_sel_q        <= rd_sel_d;
      rd_addr_q       <= rd_addr_d;
      iss_pm_q        <= iss_pm_d;
      iss_pn_q        <= iss_pn_d;
      in_add_valid_q  <= in_add_valid_d;
      ptr_row_q       <= ptr_row_d;
      ptr_col_q       <= ptr_col_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  // Next-state, counter and output logic.
  always_comb begin
    state_d         = state_q;
    pm_d            = pm_q;
    pn_d            = pn_q;
    row_done_seen_d = row_done_seen_q;
    rd_en_d         = 1'b0;
    rd_sel_d        = rd_sel_q;
    rd_addr_d       = rd_addr_q;
    iss_pm_d        = iss_pm_q;
    iss_pn_d        = iss_pn_q;
    done_d          = 1'b0;

    // Data side trails the issue by the buffer's one-cycle latency; a read
    // already issued always produces its valid, even across hold or abort.
    in_add_valid_d = rd_en_q;
    ptr_row_d      = rd_en_q ? DW_INT'(iss_pm_q) : ptr_row_q;
    ptr_col_d      = rd_en_q ? DW_INT'(iss_pn_q) : ptr_col_q;

    // Remember an early row-complete so WAIT_ROW does not miss it.
    if (row_done && (state_q != S_WAIT_ROW)) begin
      row_done_seen_d = 1'b1;
    end

    if (abort) begin
      state_d         = S_IDLE;
      pm_d            = '0;
      pn_d            = '0;
      row_done_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ISSUE_A;
            pm_d    = '0;
            pn_d    = '0;
          end
        end

        S_ISSUE_A, S_ISSUE_B: begin
          // hold only gates the issue; nothing advances while it is high
          if (!hold) begin
            rd_en_d   = 1'b1;
            rd_sel_d  = (state_q == S_ISSUE_B);
            rd_addr_d = tile_addr_c;
            iss_pm_d  = pm_q;
            iss_pn_d  = pn_q;
            if (pn_q == PN_LAST) begin
              pn_d    = '0;
              state_d = (state_q == S_ISSUE_A) ? S_ISSUE_B : S_WAIT_ROW;
            end else begin
              pn_d = pn_q + PN_W'(1);
            end
          end
        end

        S_WAIT_ROW: begin
          if (row_done || row_done_seen_q) begin
            row_done_seen_d = 1'b0;
            if (pm_q == PM_LAST) begin
              state_d = S_DONE;
            end else begin
              pm_d    = pm_q + PM_W'(1);
              state_d = S_ISSUE_A;
            end
          end
        end

        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_ISSUE_A) || (state_d == S_ISSUE_B) ||
             (state_d == S_WAIT_ROW);
  end

  assign rd_en        = rd_en_q;
  assign rd_sel       = rd_sel_q;
  assign rd_addr      = rd_addr_q;
  assign ptr_row      = ptr_row_q;
  assign ptr_col      = ptr_col_q;
  assign in_add_valid = in_add_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mm_adder_ctrl.sv
// Scoreboard bench for mm_adder_ctrl: default 4x4 instance plus a 5x3 instance.
module tb_mm_adder_ctrl;

  typedef struct {int cyc; int a; int b;} exp_t;
  typedef struct {int cyc; int sig; longint val;} st_t;

  localparam int S_RD0 = 0, S_IV0 = 1, S_BUSY0 = 2, S_DONE0 = 3, S_PR0 = 4,
                 S_PC0 = 5, S_RDCNT0 = 6, S_PEND0 = 7, S_BUSY1 = 8, S_PEND1 = 9;

  logic        clk;
  logic        reset_n;
  logic        start0, abort0, hold0, row_done0;
  logic        start1, abort1, hold1, row_done1;
  logic        rd_en0, rd_sel0, iv0, busy0, done0;
  logic        rd_en1, rd_sel1, iv1, busy1, done1;
  logic [7:0]  rd_addr0, rd_addr1;
  logic [31:0] ptr_row0, ptr_col0, ptr_row1, ptr_col1;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int rd_count0 = 0;

  exp_t q_rd0[$], q_iv0[$], q_done0[$];
  exp_t q_rd1[$], q_iv1[$], q_done1[$];
  st_t  q_st[$];

  mm_adder_ctrl u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort0),
    .hold(hold0), .row_done(row_done0), .rd_en(rd_en0), .rd_sel(rd_sel0),
    .rd_addr(rd_addr0), .ptr_row(ptr_row0), .ptr_col(ptr_col0),
    .in_add_valid(iv0), .busy(busy0), .done(done0)
  );

  mm_adder_ctrl #(.M(5), .N(3), .M_TILE(2), .N_TILE(2), .DW_INT(32), .ADDR_W(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1),
    .hold(hold1), .row_done(row_done1), .rd_en(rd_en1), .rd_sel(rd_sel1),
    .rd_addr(rd_addr1), .ptr_row(ptr_row1), .ptr_col(ptr_col1),
    .in_add_valid(iv1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected summary before timeout");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] probe(input int s);
    case (s)
      S_RD0:    probe = 64'(rd_en0);
      S_IV0:    probe = 64'(iv0);
      S_BUSY0:  probe = 64'(busy0);
      S_DONE0:  probe = 64'(done0);
      S_PR0:    probe = 64'(ptr_row0);
      S_PC0:    probe = 64'(ptr_col0);
      S_RDCNT0: probe = 64'(rd_count0);
      S_PEND0:  probe = 64'(q_rd0.size() + q_iv0.size() + q_done0.size());
      S_BUSY1:  probe = 64'(busy1);
      S_PEND1:  probe = 64'(q_rd1.size() + q_iv1.size() + q_done1.size());
      default:  probe = '1;
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_RD0:    sig_name = "rd_en0";
      S_IV0:    sig_name = "in_add_valid0";
      S_BUSY0:  sig_name = "busy0";
      S_DONE0:  sig_name = "done0";
      S_PR0:    sig_name = "ptr_row0";
      S_PC0:    sig_name = "ptr_col0";
      S_RDCNT0: sig_name = "read_count0";
      S_PEND0:  sig_name = "pending_expect0";
      S_BUSY1:  sig_name = "busy1";
      S_PEND1:  sig_name = "pending_expect1";
      default:  sig_name = "unknown";
    endcase
  endfunction

  task automatic chk(input string name, input int c, input logic [63:0] act,
                     input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, c, act, expv);
    end
  endtask

  task automatic unexpected(input string name, input int c);
    n_checks++;
    n_errors++;
    $display("FAIL %s @cyc %0d: got an output pulse, expected none", name, c);
  endtask

  // Monitor: pops and compares whenever a DUT presents an output.
  always @(negedge clk) begin : mon
    exp_t e;
    st_t  s;
    if (reset_n) begin
      if (rd_en0) begin
        rd_count0 = rd_count0 + 1;
        if (q_rd0.size() == 0) unexpected("rd0", cyc);
        else begin
          e = q_rd0.pop_front();
          chk("rd0_cycle", cyc, 64'(cyc), 64'(e.cyc));
          chk("rd0_sel", cyc, 64'(rd_sel0), 64'(e.a));
          chk("rd0_addr", cyc, 64'(rd_addr0), 64'(e.b));
        end
      end
      if (iv0) begin
        if (q_iv0.size() == 0) unexpected("iv0", cyc);
        else begin
          e = q_iv0.pop_front();
          chk("iv0_cycle", cyc, 64'(cyc), 64'(e.cyc));
          chk("iv0_ptr_row", cyc, 64'(ptr_row0), 64'(e.a));
          chk("iv0_ptr_col", cyc, 64'(ptr_col0), 64'(e.b));
        end
      end
      if (done0) begin
        if (q_done0.size() == 0) unexpected("done0", cyc);
        else begin
          e = q_done0.pop_front();
          chk("done0_cycle", cyc, 64'(cyc), 64'(e.cyc));
        end
      end
      if (rd_en1) begin
        if (q_rd1.size() == 0) unexpected("rd1", cyc);
        else begin
          e = q_rd1.pop_front();
          chk("rd1_cycle", cyc, 64'(cyc), 64'(e.cyc));
          chk("rd1_sel", cyc, 64'(rd_sel1), 64'(e.a));
          chk("rd1_addr", cyc, 64'(rd_addr1), 64'(e.b));
        end
      end
      if (iv1) begin
        if (q_iv1.size() == 0) unexpected("iv1", cyc);
        else begin
          e = q_iv1.pop_front();
          chk("iv1_cycle", cyc, 64'(cyc), 64'(e.cyc));
          chk("iv1_ptr_row", cyc, 64'(ptr_row1), 64'(e.a));
          chk("iv1_ptr_col", cyc, 64'(ptr_col1), 64'(e.b));
        end
      end
      if (done1) begin
        if (q_done1.size() == 0) unexpected("done1", cyc);
        else begin
          e = q_done1.pop_front();
          chk("done1_cycle", cyc, 64'(cyc), 64'(e.cyc));
        end
      end
    end
    while (q_st.size() != 0 && q_st[0].cyc <= cyc) begin
      s = q_st.pop_front();
      chk(sig_name(s.sig), cyc, probe(s.sig), 64'(s.val));
    end
  end

  // ---- expectation helpers ----
  task automatic st(input int c, input int s, input longint v);
    st_t x;
    x.cyc = c; x.sig = s; x.val = v;
    q_st.push_back(x);
  endtask

  task automatic push_rd(input int d, input int c, input int sel, input int addr);
    exp_t x;
    x.cyc = c; x.a = sel; x.b = addr;
    if (d == 0) q_rd0.push_back(x); else q_rd1.push_back(x);
  endtask

  task automatic push_iv(input int d, input int c, input int r, input int col);
    exp_t x;
    x.cyc = c; x.a = r; x.b = col;
    if (d == 0) q_iv0.push_back(x); else q_iv1.push_back(x);
  endtask

  task automatic push_done(input int d, input int c);
    exp_t x;
    x.cyc = c; x.a = 0; x.b = 0;
    if (d == 0) q_done0.push_back(x); else q_done1.push_back(x);
  endtask

  // One uninterrupted row-block (ITER_N = 2): A0,A1,B0,B1 from edge base+1.
  task automatic push_row(input int d, input int base, input int pm);
    for (int k = 0; k < 4; k++) begin
      push_rd(d, base + 1 + k, k / 2, pm * 2 + (k % 2));
      push_iv(d, base + 2 + k, pm, k % 2);
    end
  endtask

  // ---- stimulus helpers ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_start0(output int t);
    start0 = 1'b1; step(); start0 = 1'b0; t = cyc;
  endtask

  task automatic pulse_rd0(input int edge_c);
    wait_cyc(edge_c - 1); row_done0 = 1'b1; step(); row_done0 = 1'b0;
  endtask

  task automatic pulse_rd1(input int edge_c);
    wait_cyc(edge_c - 1); row_done1 = 1'b1; step(); row_done1 = 1'b0;
  endtask

  task automatic nominal0();
    int t;
    int base;
    base = rd_count0;
    do_start0(t);
    push_row(0, t, 0);
    push_row(0, t + 7, 1);
    push_done(0, t + 15);
    st(t, S_BUSY0, 1);
    st(t + 5, S_BUSY0, 1);
    st(t + 6, S_IV0, 0);
    st(t + 6, S_PR0, 0);
    st(t + 6, S_PC0, 1);
    st(t + 16, S_BUSY0, 0);
    st(t + 16, S_DONE0, 0);
    st(t + 16, S_RDCNT0, base + 8);
    st(t + 16, S_PEND0, 0);
    pulse_rd0(t + 7);
    pulse_rd0(t + 14);
    wait_cyc(t + 17);
  endtask

  initial begin : stim
    int t;
    int base;
    start0 = 0; abort0 = 0; hold0 = 0; row_done0 = 0;
    start1 = 0; abort1 = 0; hold1 = 0; row_done1 = 0;
    reset_n = 1'b1;

    // Outputs are zero during reset and right after release.
    st(1, S_RD0, 0); st(1, S_IV0, 0); st(1, S_BUSY0, 0); st(1, S_DONE0, 0);
    st(1, S_PR0, 0); st(1, S_PC0, 0);
    st(4, S_RD0, 0); st(4, S_IV0, 0); st(4, S_BUSY0, 0); st(4, S_DONE0, 0);
    st(4, S_BUSY1, 0);
    #2 reset_n = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(5);

    // Nominal two-row run.
    nominal0();

    // hold for three issue slots starting at the second issue.
    base = rd_count0;
    do_start0(t);
    push_rd(0, t + 1, 0, 0); push_rd(0, t + 5, 0, 1);
    push_rd(0, t + 6, 1, 0); push_rd(0, t + 7, 1, 1);
    push_iv(0, t + 2, 0, 0); push_iv(0, t + 6, 0, 1);
    push_iv(0, t + 7, 0, 0); push_iv(0, t + 8, 0, 1);
    push_row(0, t + 10, 1);
    push_done(0, t + 18);
    st(t + 2, S_RD0, 0);
    st(t + 3, S_RD0, 0); st(t + 3, S_IV0, 0);
    st(t + 4, S_RD0, 0); st(t + 4, S_IV0, 0);
    st(t + 19, S_RDCNT0, base + 8);
    st(t + 19, S_PEND0, 0);
    wait_cyc(t + 1); hold0 = 1'b1;
    wait_cyc(t + 4); hold0 = 1'b0;
    pulse_rd0(t + 10);
    pulse_rd0(t + 17);
    wait_cyc(t + 20);

    // Early row_done during ISSUE_B of row 0; row 1 still needs its own.
    do_start0(t);
    push_row(0, t, 0);
    push_row(0, t + 5, 1);
    push_done(0, t + 16);
    st(t + 14, S_BUSY0, 1);
    st(t + 17, S_BUSY0, 0);
    st(t + 17, S_PEND0, 0);
    pulse_rd0(t + 3);
    pulse_rd0(t + 15);
    wait_cyc(t + 18);

    // abort during ISSUE_B of row 1: in-flight read still completes, no done.
    do_start0(t);
    push_row(0, t, 0);
    push_rd(0, t + 7, 0, 2); push_rd(0, t + 8, 0, 3);
    push_iv(0, t + 8, 1, 0); push_iv(0, t + 9, 1, 1);
    st(t + 9, S_BUSY0, 0);
    st(t + 9, S_RD0, 0);
    st(t + 12, S_BUSY0, 0);
    st(t + 12, S_PEND0, 0);
    pulse_rd0(t + 6);
    wait_cyc(t + 8); abort0 = 1'b1; step(); abort0 = 1'b0;
    wait_cyc(t + 13);
    nominal0();

    // Async reset mid-ISSUE_A: outputs clear before the next clock edge.
    do_start0(t);
    push_rd(0, t + 1, 0, 0);
    st(t + 2, S_RD0, 0); st(t + 2, S_IV0, 0);
    st(t + 2, S_BUSY0, 0); st(t + 2, S_DONE0, 0);
    st(t + 5, S_RD0, 0); st(t + 5, S_IV0, 0); st(t + 5, S_BUSY0, 0);
    st(t + 5, S_PEND0, 0);
    wait_cyc(t + 2);
    reset_n = 1'b0;
    wait_cyc(t + 4);
    reset_n = 1'b1;
    wait_cyc(t + 6);
    nominal0();

    // Non-divisible 5x3 instance: ITER_M=3, ITER_N=2, 12 reads.
    start1 = 1'b1; step(); start1 = 1'b0; t = cyc;
    for (int r = 0; r < 3; r++) push_row(1, t + 7 * r, r);
    push_done(1, t + 22);
    st(t + 20, S_BUSY1, 1);
    st(t + 23, S_BUSY1, 0);
    st(t + 23, S_PEND1, 0);
    for (int r = 0; r < 3; r++) pulse_rd1(t + 7 * (r + 1));
    wait_cyc(t + 25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
